// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory responder: MMIO map, TXSTAT layout
// and the access-alignment helper.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    localparam logic [4:0] OFF_TXDATA      = 5'h00;
    localparam logic [4:0] OFF_TXSTAT      = 5'h04;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;

    localparam int TXSTAT_FULL  = 0;
    localparam int TXSTAT_EMPTY = 1;
    localparam int TXSTAT_OVF   = 2;
    localparam int TXSTAT_COUNT = 3;

    // Number of byte-offset bits below a data word.
    function automatic int align_of(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Console TX byte FIFO. Full is judged before the same-cycle pop, so a push
// into a full FIFO is always dropped and flagged in the sticky overflow bit.
module tx_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       data,
    output logic             full,
    input  logic             pop,
    output logic [7:0]       head,
    output logic [FIFO_AW:0] count,
    output logic             empty,
    input  logic             ovf_clr,
    output logic             overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               do_push, do_pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    // Gate the head with empty so the port reads 0 out of reset.
    assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (push && full)
            ovf_d = 1'b1;
    end

    // Control state, cleared asynchronously so queued bytes vanish on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM, machine timer and console TX FIFO
// behind the core's MEM-stage interface, with combinational load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RAM_AW   = 12,
    parameter int FIFO_AW  = 3,
    parameter int TICK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            timer_irq
);
    localparam int ALIGN   = align_of(XLEN);
    localparam int RAM_TOP = RAM_AW + ALIGN;
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [XLEN-1:0] BASE = XLEN'(MMIO_BASE);

    logic [XLEN-1:0]   ram_q [2 ** RAM_AW];
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              irq_q, irq_d;
    logic              tick;

    logic              access, ram_hit, mmio_hit, wr_mmio;
    logic [4:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic [XLEN-1:0]   mmio_rdata;
    logic [31:0]       txstat;
    logic              unused_addr_bits;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf, ovf_clr;
    logic [7:0]        fifo_head;
    logic [FIFO_AW:0]  fifo_count;

    assign access   = mem_load | mem_store;
    assign ram_hit  = (address[XLEN-1:RAM_TOP] == '0);
    assign mmio_hit = (address[XLEN-1:5] == BASE[XLEN-1:5]);
    // Registers sit on 4-byte offsets even for XLEN=64, so MMIO decodes
    // down to bit 2 regardless of the word alignment.
    assign mmio_off = {address[4:2], 2'b00};
    assign ram_idx  = address[RAM_TOP-1:ALIGN];
    assign wr_mmio  = mem_store & mmio_hit;
    assign unused_addr_bits = ^address[1:0];

    assign fifo_push = wr_mmio && (mmio_off == OFF_TXDATA);
    assign ovf_clr   = wr_mmio && (mmio_off == OFF_TXSTAT) && store_data[TXSTAT_OVF];
    assign tx_valid  = ~fifo_empty;
    assign fifo_pop  = tx_valid & tx_ready;
    assign tx_data   = fifo_head;
    assign timer_irq = irq_q;

    tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .data     (store_data[7:0]),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .ovf_clr  (ovf_clr),
        .overflow (fifo_ovf)
    );

    // Assemble the TXSTAT status word.
    always_comb begin
        txstat = '0;
        txstat[TXSTAT_FULL]  = fifo_full;
        txstat[TXSTAT_EMPTY] = fifo_empty;
        txstat[TXSTAT_OVF]   = fifo_ovf;
        txstat[TXSTAT_COUNT +: FIFO_AW + 1] = fifo_count;
    end

    // MMIO read mux; TXDATA and unmapped offsets read as zero.
    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_TXSTAT:      mmio_rdata = XLEN'(txstat);
            OFF_MTIME_LO:    mmio_rdata = mtime_q[XLEN-1:0];
            OFF_MTIME_HI:    mmio_rdata = XLEN'(mtime_q[63:32]);
            OFF_MTIMECMP_LO: mmio_rdata = mtimecmp_q[XLEN-1:0];
            OFF_MTIMECMP_HI: mmio_rdata = XLEN'(mtimecmp_q[63:32]);
            default:         mmio_rdata = '0;
        endcase
    end

    // Load data is also driven during stores for the core's sub-word merge.
    always_comb begin
        load_data = '0;
        if (access) begin
            if (ram_hit)
                load_data = ram_q[ram_idx];
            else if (mmio_hit)
                load_data = mmio_rdata;
        end
    end

    // Data RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (mem_store && ram_hit)
            ram_q[ram_idx] <= store_data;
    end

    // Timer next-state: prescaled increment, overridden by a CPU write.
    always_comb begin
        tick       = (presc_q == PW'(TICK_DIV - 1));
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        irq_d      = (mtime_q >= mtimecmp_q);
        if (wr_mmio) begin
            case (mmio_off)
                OFF_MTIME_LO: begin
                    mtime_d = mtime_q;
                    mtime_d[XLEN-1:0] = store_data;
                end
                OFF_MTIME_HI: begin
                    mtime_d = mtime_q;
                    mtime_d[63:32] = store_data[31:0];
                end
                OFF_MTIMECMP_LO: mtimecmp_d[XLEN-1:0] = store_data;
                OFF_MTIMECMP_HI: mtimecmp_d[63:32] = store_data[31:0];
                default: ;
            endcase
        end
    end

    // Timer state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, TX FIFO, timer, wrap and async reset.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_TXSTAT = 32'h1000_0004;
    localparam logic [31:0] A_MT_LO  = 32'h1000_0008;
    localparam logic [31:0] A_MT_HI  = 32'h1000_000C;
    localparam logic [31:0] A_CMP_LO = 32'h1000_0010;
    localparam logic [31:0] A_CMP_HI = 32'h1000_0014;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_load, mem_store, tx_ready;
    logic [31:0] address, store_data, load_data;
    logic        tx_valid, timer_irq;
    logic [7:0]  tx_data;

    logic        t4_load, t4_store, t4_ready;
    logic [31:0] t4_addr, t4_wdata, t4_rdata;
    logic        t4_valid, t4_irq;
    logic [7:0]  t4_txdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;

    always #5 clock = ~clock;

    dmem_responder #(.XLEN(32), .RAM_AW(12), .FIFO_AW(3), .TICK_DIV(1)) u_dut (
        .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
        .address(address), .store_data(store_data), .load_data(load_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .timer_irq(timer_irq)
    );

    dmem_responder #(.XLEN(32), .RAM_AW(12), .FIFO_AW(3), .TICK_DIV(4)) u_tick4 (
        .clock(clock), .reset(reset), .mem_load(t4_load), .mem_store(t4_store),
        .address(t4_addr), .store_data(t4_wdata), .load_data(t4_rdata),
        .tx_valid(t4_valid), .tx_data(t4_txdata), .tx_ready(t4_ready), .timer_irq(t4_irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_store  = 1'b1;
        address    = a;
        store_data = d;
        step();
        mem_store  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        mem_load = 1'b1;
        address  = a;
        #1;
        d = load_data;
        mem_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_load = 1'b0; mem_store = 1'b0; tx_ready = 1'b0;
        address = '0; store_data = '0;
        t4_load = 1'b1; t4_store = 1'b0; t4_ready = 1'b0;
        t4_addr = A_MT_LO; t4_wdata = '0;
        #12;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_irq", timer_irq, 0);
        load(A_CMP_LO, rd); check("rst_mtimecmp_lo", rd, 32'hFFFF_FFFF);
        load(A_TXSTAT, rd); check("rst_txstat", rd, 32'h2);
        reset = 1'b0;
        step();
        load(A_MT_LO, rd); check("mtime_first_tick", rd, 1);

        // TICK_DIV=4 instance: one increment per four edges.
        step(); step();
        check("tick4_3edges", t4_rdata, 0);
        step();
        check("tick4_4edges", t4_rdata, 1);
        repeat (4) step();
        check("tick4_8edges", t4_rdata, 2);

        // RAM
        store(32'h40, 32'h1111_1111);
        mem_store = 1'b1; address = 32'h40; store_data = 32'hDEAD_BEEF;
        #1; check("ram_old_in_store_cycle", load_data, 32'h1111_1111);
        step(); mem_store = 1'b0;
        load(32'h40, rd); check("ram_readback", rd, 32'hDEAD_BEEF);
        address = 32'h40; #1; check("idle_load_zero", load_data, 0);
        store(32'h0, 32'h1234_5678);
        store(32'h4000, 32'h5555_5555);
        load(32'h0, rd); check("ram_no_alias", rd, 32'h1234_5678);
        load(32'h4000, rd); check("above_ram_zero", rd, 0);
        store(32'h3FFC, 32'hA5A5_A5A5);
        load(32'h3FFC, rd); check("ram_top_word", rd, 32'hA5A5_A5A5);
        load(32'h2000_0000, rd); check("unmapped_zero", rd, 0);
        mem_load = 1'b1; mem_store = 1'b1; address = 32'h40; store_data = 32'hCAFE_F00D;
        #1; check("load_store_both_old", load_data, 32'hDEAD_BEEF);
        step(); mem_load = 1'b0; mem_store = 1'b0;
        load(32'h40, rd); check("load_store_both_new", rd, 32'hCAFE_F00D);

        // TX single byte
        store(A_TXDATA, 32'h0000_00AB);
        check("tx_valid_after_push", tx_valid, 1);
        check("tx_data_after_push", tx_data, 8'hAB);
        load(A_TXDATA, rd); check("txdata_reads_zero", rd, 0);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        check("tx_valid_after_pop", tx_valid, 0);

        // FIFO full and overflow
        for (int i = 1; i <= 9; i++) store(A_TXDATA, i);
        load(A_TXSTAT, rd); check("txstat_full_ovf", rd, 32'h45);
        step(); step();
        check("tx_data_held", tx_data, 8'h01);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", tx_valid, 1);
            check("drain_byte", tx_data, i);
            step();
        end
        tx_ready = 1'b0;
        check("drained_empty", tx_valid, 0);
        load(A_TXSTAT, rd); check("txstat_empty_ovf", rd, 32'h6);
        store(A_TXSTAT, 32'h4);
        load(A_TXSTAT, rd); check("txstat_ovf_cleared", rd, 32'h2);
        for (int i = 0; i < 8; i++) store(A_TXDATA, 32'h11 + i);
        load(A_TXSTAT, rd); check("txstat_full_no_ovf", rd, 32'h41);
        tx_ready = 1'b1;
        store(A_TXDATA, 32'h99);
        tx_ready = 1'b0;
        load(A_TXSTAT, rd); check("txstat_push_pop_full", rd, 32'h3C);
        tx_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check("drain2_byte", tx_data, 32'h11 + i);
            step();
        end
        tx_ready = 1'b0;
        check("drain2_empty", tx_valid, 0);
        store(A_TXSTAT, 32'h4);

        // Timer compare (TICK_DIV=1)
        store(A_MT_HI, 0);
        store(A_MT_LO, 0);
        store(A_CMP_HI, 0);
        store(A_CMP_LO, 20);
        load(A_MT_LO, rd); check("mtime_after_setup", rd, 2);
        check("irq_low_setup", timer_irq, 0);
        repeat (18) step();
        load(A_MT_LO, rd); check("mtime_at_20", rd, 20);
        check("irq_not_yet", timer_irq, 0);
        step();
        check("irq_rises", timer_irq, 1);
        store(A_MT_LO, 0);
        check("irq_still_high", timer_irq, 1);
        load(A_MT_LO, rd); check("mtime_written_0", rd, 0);
        step();
        check("irq_falls", timer_irq, 0);
        load(A_MT_LO, rd); check("mtime_after_write", rd, 1);

        // 64-bit wrap; a HI write suppresses that cycle's increment
        store(A_MT_HI, 32'hFFFF_FFFF);
        load(A_MT_LO, rd); check("hi_write_no_inc", rd, 1);
        load(A_MT_HI, rd); check("mtime_hi_written", rd, 32'hFFFF_FFFF);
        store(A_MT_LO, 32'hFFFF_FFFE);
        load(A_MT_LO, rd); check("mtime_lo_fffe", rd, 32'hFFFF_FFFE);
        step();
        load(A_MT_LO, rd); check("mtime_lo_ffff", rd, 32'hFFFF_FFFF);
        step();
        load(A_MT_LO, rd); check("wrap_lo", rd, 0);
        load(A_MT_HI, rd); check("wrap_hi", rd, 0);

        // Async reset mid-operation
        store(A_CMP_LO, 0);
        for (int i = 0; i < 3; i++) store(A_TXDATA, 32'h31 + i);
        check("pre_reset_valid", tx_valid, 1);
        check("pre_reset_irq", timer_irq, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_irq", timer_irq, 0);
        #1 reset = 1'b0;
        load(A_TXSTAT, rd); check("post_reset_txstat", rd, 32'h2);
        step();
        check("post_reset_irq", timer_irq, 0);
        check("post_reset_valid", tx_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
